pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Owns the architectural PC and sequences fetch for the 5-stage pipeline.
- Selects the next PC each cycle from: sequential PC+2, a taken-branch redirect from ID (target/register address produced by the branch address logic), or hold.
- Drives IF/ID write-enable and flush, parks a redirect that arrives during an I-cache miss, and freezes fetch on HLT.
- Sits between the I-cache/fetch path and the ID-stage branch resolution logic.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- HALT_OPC, 4'hF, instruction[15:12] opcode of HLT.

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- br_taken  in  1  ID stage: branch resolved taken this cycle
- br_target  in  16  ID stage: final redirect address, valid with br_taken
- id_stall  in  1  hazard unit: ID must hold (load-use)
- icache_stall  in  1  I-cache miss: fetch at pc not returned this cycle
- if_instr  in  16  instruction returned for pc, valid when icache_stall=0
- pc  out  16  current fetch address (registered)
- pc_plus2  out  16  pc+2, combinational, wraps mod 2^16
- fetch_req  out  1  I-cache read request for pc
- if_id_write  out  1  IF/ID pipeline register enable
- if_id_flush  out  1  IF/ID loads NOP this cycle
- halted  out  1  HLT fetched; fetch frozen
- redirect_cnt  out  16  taken redirects performed, saturating

Behaviour:
- Reset (rst_n=0, asynchronous): pc=RESET_PC, state=RUN, pend_addr=0, redirect_cnt=0, halted=0. Reset mid-miss or mid-pending discards all state.
- States: RUN, REDIR_PEND, HALT.
- br_taken is qualified: redir = br_taken & ~id_stall, because a branch held in ID is not yet resolved.
- RUN, evaluated in priority order:
  1. redir & ~icache_stall: pc<=br_target, if_id_flush=1, if_id_write=1, redirect_cnt++. HLT in if_instr is ignored, since it is on the wrong path.
  2. redir & icache_stall: pend_addr<=br_target, go to REDIR_PEND, if_id_flush=1, if_id_write=1, pc holds, redirect_cnt++.
  3. id_stall: pc holds, if_id_write=0, if_id_flush=0. Any returned instruction is refetched later.
  4. icache_stall: pc holds, if_id_write=1, if_id_flush=1 (bubble).
  5. if_instr[15:12]==HALT_OPC: HLT latched into IF/ID (if_id_write=1), pc holds, go to HALT.
  6. Otherwise: pc<=pc_plus2, if_id_write=1, if_id_flush=0.
- REDIR_PEND:
  - fetch_req=1, if_id_write=1, if_id_flush=1 every cycle, so the wrong-path fetch is discarded.
  - br_taken and id_stall are ignored; ID is holding a bubble.
  - When icache_stall=0: pc<=pend_addr, go to RUN.
- HALT:
  - fetch_req=0, halted=1, pc frozen, if_id_write=1, if_id_flush=1.
  - A redir in the first HALT cycle (branch older than HLT) sets pc<=br_target, returns to RUN, and increments redirect_cnt.
  - Otherwise the block stays in HALT until reset.
- fetch_req=1 in RUN and REDIR_PEND.
- redirect_cnt saturates at 16'hFFFF; it does not wrap.
- pc_plus2 is always pc+2 mod 2^16, so 16'hFFFE gives 16'h0000.
- pc stays even. Odd br_target is forced even: bit0 is cleared on load.

Test Plan:
- Reset/sequential: rst_n low, release. Required: pc=0000, then 0002, 0004, 0006 on three clean cycles; if_id_flush=0; redirect_cnt=0.
- Redirect: at pc=0010, br_taken=1, br_target=0040, no stalls. Required: if_id_flush=1 that cycle, next pc=0040, redirect_cnt=1.
- Redirect during miss: pc=0020, icache_stall=1, br_taken=1, br_target=0100. Hold icache_stall 3 more cycles. Required: state REDIR_PEND; pc holds 0020 with flush=1 throughout; pc=0100 on the cycle after icache_stall drops.
- Load-use gating: id_stall=1 with br_taken=1, br_target=0200. Required: pc holds, if_id_write=0, no redirect, redirect_cnt unchanged. Then id_stall=0, br_taken=1. Required: pc=0200.
- Halt: if_instr=F000 at pc=0030. Required: pc stays 0030, halted=1 and fetch_req=0 next cycle and for 10 more cycles. Variant: HLT with same-cycle br_taken, br_target=0050. Required: no halt, pc=0050.
- Boundaries:
  - pc=FFFE sequential step. Required: pc=0000.
  - redirect_cnt preset near FFFF, two redirects. Required: stays FFFF.
  - br_target=0043. Required: pc=0042.
  - rst_n pulsed low in REDIR_PEND. Required: pc=0000, state RUN immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_seq_if.sv
// Fetch/branch-resolution handshake between the PC sequencer and its neighbours.
// The slave modport is the sequencer; the master modport is the fetch/ID environment.
interface pc_seq_if;
  logic        br_taken;
  logic [15:0] br_target;
  logic        id_stall;
  logic        icache_stall;
  logic [15:0] if_instr;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        fetch_req;
  logic        if_id_write;
  logic        if_id_flush;
  logic        halted;
  logic [15:0] redirect_cnt;

  modport slave (
    input  br_taken, br_target, id_stall, icache_stall, if_instr,
    output pc, pc_plus2, fetch_req, if_id_write, if_id_flush, halted, redirect_cnt
  );

  modport master (
    output br_taken, br_target, id_stall, icache_stall, if_instr,
    input  pc, pc_plus2, fetch_req, if_id_write, if_id_flush, halted, redirect_cnt
  );
endinterface

// File: rtl/pc_sequencer.sv
// Architectural PC owner: selects sequential/redirect/hold, drives IF/ID control,
// parks redirects that land during an I-cache miss and freezes fetch on HLT.
module pc_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  HALT_OPC = 4'hF
) (
  input  logic      clk,
  input  logic      rst_n,
  pc_seq_if.slave   bus
);

  // state       | meaning
  // S_RUN       | normal fetch, next pc chosen by priority rules
  // S_REDIR_PEND| redirect parked in r_pend_addr until the miss returns
  // S_HALT      | HLT fetched, fetch frozen until reset
  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_REDIR_PEND = 2'd1,
    S_HALT       = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_pc, w_pc_nxt;
  logic [15:0] r_pend_addr, w_pend_nxt;
  logic [15:0] r_redirect_cnt;
  logic        r_halt_first, w_halt_first_nxt;
  logic        w_cnt_inc;
  logic        w_redir;
  logic        w_is_hlt;
  logic [15:0] w_target_even;
  logic [15:0] w_pc_plus2;
  logic        w_fetch_req;
  logic        w_if_id_write;
  logic        w_if_id_flush;
  logic        w_halted;

  // A branch still held in ID is not resolved yet.
  assign w_redir       = bus.br_taken & ~bus.id_stall;
  assign w_is_hlt      = (bus.if_instr[15:12] == HALT_OPC);
  assign w_target_even = {bus.br_target[15:1], 1'b0};
  assign w_pc_plus2    = r_pc + 16'd2;

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_pend_nxt       = r_pend_addr;
    w_halt_first_nxt = 1'b0;
    w_cnt_inc        = 1'b0;
    w_fetch_req      = 1'b0;
    w_if_id_write    = 1'b0;
    w_if_id_flush    = 1'b0;
    w_halted         = 1'b0;

    case (r_state)
      S_RUN: begin
        w_fetch_req = 1'b1;
        if (w_redir && !bus.icache_stall) begin
          w_pc_nxt      = w_target_even;
          w_if_id_write = 1'b1;
          w_if_id_flush = 1'b1;
          w_cnt_inc     = 1'b1;
        end else if (w_redir) begin
          w_pend_nxt    = w_target_even;
          w_state_nxt   = S_REDIR_PEND;
          w_if_id_write = 1'b1;
          w_if_id_flush = 1'b1;
          w_cnt_inc     = 1'b1;
        end else if (bus.id_stall) begin
          w_if_id_write = 1'b0;
        end else if (bus.icache_stall) begin
          w_if_id_write = 1'b1;
          w_if_id_flush = 1'b1;
        end else if (w_is_hlt) begin
          w_if_id_write    = 1'b1;
          w_state_nxt      = S_HALT;
          w_halt_first_nxt = 1'b1;
        end else begin
          w_pc_nxt      = w_pc_plus2;
          w_if_id_write = 1'b1;
        end
      end

      S_REDIR_PEND: begin
        w_fetch_req   = 1'b1;
        w_if_id_write = 1'b1;
        w_if_id_flush = 1'b1;
        if (!bus.icache_stall) begin
          w_pc_nxt    = r_pend_addr;
          w_state_nxt = S_RUN;
        end
      end

      S_HALT: begin
        w_halted      = 1'b1;
        w_if_id_write = 1'b1;
        w_if_id_flush = 1'b1;
        // Only a branch older than the HLT may still pull us out.
        if (r_halt_first && w_redir) begin
          w_pc_nxt    = w_target_even;
          w_state_nxt = S_RUN;
          w_cnt_inc   = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_RUN;
      r_pc           <= RESET_PC;
      r_pend_addr    <= 16'h0000;
      r_redirect_cnt <= 16'h0000;
      r_halt_first   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_pend_addr  <= w_pend_nxt;
      r_halt_first <= w_halt_first_nxt;
      if (w_cnt_inc && (r_redirect_cnt != 16'hFFFF))
        r_redirect_cnt <= r_redirect_cnt + 16'd1;
    end
  end

  assign bus.pc           = r_pc;
  assign bus.pc_plus2     = w_pc_plus2;
  assign bus.fetch_req    = w_fetch_req;
  assign bus.if_id_write  = w_if_id_write;
  assign bus.if_id_flush  = w_if_id_flush;
  assign bus.halted       = w_halted;
  assign bus.redirect_cnt = r_redirect_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model of the fetch rules.
module tb_pc_sequencer;

  logic clk;
  logic rst_n;
  pc_seq_if bus ();

  pc_sequencer #(.RESET_PC(16'h0000), .HALT_OPC(4'hF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  // Behavioural model: where fetch is, whether a redirect is parked, whether frozen.
  int          m_pc;
  int          m_cnt;
  bit          m_parked;
  int          m_park_addr;
  bit          m_frozen;
  int          m_frozen_age;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_pc         = 0;
    m_cnt        = 0;
    m_parked     = 1'b0;
    m_park_addr  = 0;
    m_frozen     = 1'b0;
    m_frozen_age = 0;
  endtask

  // Called at a negedge; leaves at the following negedge.
  task automatic step(input bit tk, input logic [15:0] tgt, input bit ids, input bit ics,
                      input logic [15:0] instr, input bit do_chk);
    bit e_fetch, e_write, e_flush, e_halt, redir;
    bus.br_taken     = tk;
    bus.br_target    = tgt;
    bus.id_stall     = ids;
    bus.icache_stall = ics;
    bus.if_instr     = instr;
    #1;
    redir = tk && !ids;
    if (m_parked) begin
      e_fetch = 1; e_write = 1; e_flush = 1; e_halt = 0;
    end else if (m_frozen) begin
      e_fetch = 0; e_write = 1; e_flush = 1; e_halt = 1;
    end else begin
      e_fetch = 1; e_halt = 0;
      if (redir)     begin e_write = 1; e_flush = 1; end
      else if (ids)  begin e_write = 0; e_flush = 0; end
      else if (ics)  begin e_write = 1; e_flush = 1; end
      else           begin e_write = 1; e_flush = 0; end
    end
    if (do_chk) begin
      chk("pc",           bus.pc,           16'(m_pc));
      chk("pc_plus2",     bus.pc_plus2,     16'((m_pc + 2) % 65536));
      chk("fetch_req",    bus.fetch_req,    e_fetch);
      chk("if_id_write",  bus.if_id_write,  e_write);
      chk("if_id_flush",  bus.if_id_flush,  e_flush);
      chk("halted",       bus.halted,       e_halt);
      chk("redirect_cnt", bus.redirect_cnt, 16'(m_cnt));
    end
    @(posedge clk);
    if (m_parked) begin
      if (!ics) begin m_pc = m_park_addr; m_parked = 0; end
    end else if (m_frozen) begin
      if (m_frozen_age == 0 && redir) begin
        m_pc = int'(tgt) & 16'hFFFE;
        m_frozen = 0;
        if (m_cnt < 65535) m_cnt++;
      end
      m_frozen_age++;
    end else if (redir) begin
      if (m_cnt < 65535) m_cnt++;
      if (ics) begin m_parked = 1; m_park_addr = int'(tgt) & 16'hFFFE; end
      else m_pc = int'(tgt) & 16'hFFFE;
    end else if (!ids && !ics) begin
      if (instr[15:12] == 4'hF) begin m_frozen = 1; m_frozen_age = 0; end
      else m_pc = (m_pc + 2) % 65536;
    end
    @(negedge clk);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) step(0, 16'h0000, 0, 0, 16'h1000, 1);
  endtask

  // Reset asserted mid-low-phase so the asynchronous path is exercised.
  task automatic apply_reset(input bit chk_now);
    bus.br_taken = 0; bus.br_target = 0; bus.id_stall = 0;
    bus.icache_stall = 0; bus.if_instr = 16'h1000;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    if (chk_now) begin
      chk("rst_pc",    bus.pc,           16'h0000);
      chk("rst_flush", bus.if_id_flush,  1'b0);
      chk("rst_halt",  bus.halted,       1'b0);
      chk("rst_cnt",   bus.redirect_cnt, 16'h0000);
      chk("rst_fetch", bus.fetch_req,    1'b1);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    model_reset();
    bus.br_taken = 0; bus.br_target = 0; bus.id_stall = 0;
    bus.icache_stall = 0; bus.if_instr = 16'h1000;
    @(negedge clk);
    apply_reset(1);

    // Sequential fetch after reset
    quiet(1); chk("seq_pc1", bus.pc, 16'h0002);
    quiet(1); chk("seq_pc2", bus.pc, 16'h0004);
    quiet(1); chk("seq_pc3", bus.pc, 16'h0006);
    quiet(5); chk("at_0010", bus.pc, 16'h0010);

    // Clean redirect
    step(1, 16'h0040, 0, 0, 16'h1000, 1);
    chk("redir_pc", bus.pc, 16'h0040);
    chk("redir_cnt", bus.redirect_cnt, 16'h0001);

    // Redirect during an I-cache miss; branch inputs are noise while parked
    step(1, 16'h0020, 0, 0, 16'h1000, 1);
    step(1, 16'h0100, 0, 1, 16'h1000, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 16'hBEEE, 1, 1, 16'hF000, 1);
      chk("pend_pc", bus.pc, 16'h0020);
      chk("pend_flush", bus.if_id_flush, 1'b1);
    end
    step(0, 16'h0000, 0, 0, 16'h1000, 1);
    chk("pend_done_pc", bus.pc, 16'h0100);
    chk("pend_cnt", bus.redirect_cnt, 16'h0003);

    // Load-use hold gates the branch
    step(1, 16'h0200, 1, 0, 16'h1000, 1);
    chk("lu_pc", bus.pc, 16'h0100);
    chk("lu_cnt", bus.redirect_cnt, 16'h0003);
    step(1, 16'h0200, 0, 0, 16'h1000, 1);
    chk("lu_redir_pc", bus.pc, 16'h0200);

    // Halt: frozen for many cycles, late branches ignored
    step(1, 16'h0030, 0, 0, 16'h1000, 1);
    step(0, 16'h0000, 0, 0, 16'hF000, 1);
    for (int i = 0; i < 11; i++) begin
      step((i == 3), 16'h0500, 0, 0, 16'h1000, 1);
      chk("halt_pc", bus.pc, 16'h0030);
      chk("halt_flag", bus.halted, 1'b1);
      chk("halt_fetch", bus.fetch_req, 1'b0);
    end
    apply_reset(1);

    // HLT on the wrong path of a same-cycle redirect
    step(1, 16'h0050, 0, 0, 16'hF000, 1);
    chk("hlt_wrongpath_pc", bus.pc, 16'h0050);
    chk("hlt_wrongpath_halt", bus.halted, 1'b0);
    // Older branch in the first HALT cycle
    step(0, 16'h0000, 0, 0, 16'hF123, 1);
    step(1, 16'h0060, 0, 0, 16'h1000, 1);
    chk("hlt_escape_pc", bus.pc, 16'h0060);
    chk("hlt_escape_halt", bus.halted, 1'b0);

    // Wrap at top of address space and odd target
    step(1, 16'hFFFE, 0, 0, 16'h1000, 1);
    quiet(1);
    chk("wrap_pc", bus.pc, 16'h0000);
    step(1, 16'h0043, 0, 0, 16'h1000, 1);
    chk("odd_target_pc", bus.pc, 16'h0042);

    // Asynchronous reset while a redirect is parked
    step(1, 16'h0300, 0, 1, 16'h1000, 1);
    step(0, 16'h0000, 0, 1, 16'h1000, 1);
    apply_reset(1);
    quiet(2);

    // Randomized traffic against the model
    for (int ep = 0; ep < 20; ep++) begin
      for (int c = 0; c < 150; c++) begin
        bit tk, ids, ics;
        logic [15:0] tgt, ins;
        tk  = ($urandom_range(0, 3) == 0);
        ids = ($urandom_range(0, 4) == 0);
        ics = ($urandom_range(0, 2) == 0);
        tgt = 16'($urandom);
        ins = 16'($urandom_range(0, 16'hEFFF));
        if ($urandom_range(0, 29) == 0) ins = {4'hF, ins[11:0]};
        step(tk, tgt, ids, ics, ins, 1);
      end
      apply_reset(0);
    end

    // Saturation of the redirect counter
    apply_reset(0);
    while (m_cnt < 65533) step(1, 16'h0100, 0, 0, 16'h1000, 0);
    for (int i = 0; i < 4; i++) step(1, 16'h0200, 0, 0, 16'h1000, 1);
    chk("sat_cnt", bus.redirect_cnt, 16'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
